rps_match_controller: RTL
=========================

# rps_match_controller

Match sequencer for the stone-paper-scissors game. It runs a multi-round match between two players and collects each player's move over its own valid/ready handshake. It evaluates each round with the standard stone/paper/scissors rules and keeps per-player scores. It declares the match winner when a player reaches a target score or when the round limit runs out, and it sits between the player input front-end and the display/status logic.

## Interface
- WIN_TARGET, 3, score that ends the match (1..15)
- MAX_ROUNDS, 9, rounds before a forced finish (1..15)
- TIMEOUT_CYCLES, 200, COLLECT cycles allowed per round (1..255)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  in IDLE or DONE: begin a new match
- abort  in  1  any state: return to IDLE
- p1_valid / p2_valid  in  1  player move offered
- p1_move / p2_move  in  2  00 stone, 01 paper, 10 scissors, 11 invalid
- p1_ready / p2_ready  out  1  controller accepts that player's move
- round_valid  out  1  one-cycle pulse, round result and scores valid
- round_result  out  2  00 tie, 01 P1, 10 P2, 11 invalid/no-contest
- p1_score / p2_score  out  4  round wins this match
- round_count  out  4  rounds completed this match
- match_done  out  1  level, high in DONE
- match_winner  out  2  00 draw, 01 P1, 10 P2
- busy  out  1  high in COLLECT, EVAL, REPORT

## Operation
- States: IDLE, COLLECT, EVAL, REPORT, DONE.
- Reset values: state IDLE; every output 0.
- IDLE or DONE with start=1: clear scores, round_count, match_done and match_winner, then enter COLLECT.
- abort=1 in any state: go to IDLE next edge, clear scores and round_count, drop ready. abort beats start.
- COLLECT entry: clear both captured flags and the timeout counter.
- pX_ready = state==COLLECT && !pX_captured.
- Capture pX_move on valid&&ready. Ready falls the next cycle, so there is at most one capture per player per round.
- Both captured: go to EVAL.
- The timeout counter increments every COLLECT cycle. At count TIMEOUT_CYCLES-1 with a player still uncaptured, go to EVAL. A capture on that same edge counts.
- EVAL result, registered on the EVAL→REPORT edge:
  - Either player missing: the present player wins. Both missing gives 11.
  - Either move 11 gives 11.
  - Equal moves give 00.
  - Otherwise stone beats scissors, paper beats stone, scissors beats paper.
- Same edge: winner's score +1 (none for 00/11), round_count +1, round_result updated.
- REPORT: round_valid=1 for exactly one cycle. Next state:
  - DONE if p1_score==WIN_TARGET or p2_score==WIN_TARGET.
  - DONE if round_count==MAX_ROUNDS; the higher score wins, equal scores give 00.
  - COLLECT otherwise.
- DONE: match_done=1; match_winner, scores and round_result hold until start, abort or reset.
- Width rules: scores and round_count are 4-bit and cannot exceed the parameter bounds, so there is no wrap. The timeout counter is 8-bit.

## Timing
- start sampled at edge N: COLLECT from N+1, readies high in cycle N+1.
- Last capture at edge K: EVAL during K+1, REPORT during K+2 (round_valid=1, scores already updated), next state at K+3.
- Minimum round, both valid waiting: 3 cycles (COLLECT, EVAL, REPORT).
- Timeout round: COLLECT lasts exactly TIMEOUT_CYCLES cycles.
- match_done rises in the cycle after the final REPORT.
- Reset asserted mid-round: outputs go to 0 immediately (asynchronously). Operation resumes in IDLE on the first edge after release.
- Moves are sampled only on capture. Changing pX_move after capture has no effect.

## Test plan
- Basic round: start; p1=00, p2=10 both valid. round_valid 3 cycles after COLLECT entry, round_result=01, p1_score=1, round_count=1.
- First to 3: P2 wins 3 straight rounds (p1=00, p2=01). match_done=1, match_winner=10, p2_score=3, round_count=3.
- Timeout: TIMEOUT_CYCLES=4, only p1 valid. EVAL after 4 COLLECT cycles, result 01. With neither valid, result 11 and no score change.
- Round limit: MAX_ROUNDS=2, one tie then one 11. match_done, match_winner=00, round_count=2, scores 0/0.
- Handshake: p1 valid early, p2 valid 5 cycles later. p1_ready drops after capture, later p1_move changes are ignored, result uses the captured value.
- Abort/reset: abort together with start in DONE stays in IDLE with all outputs 0. Reset during REPORT clears all outputs at once, with no round_valid pulse afterward.

Source files
------------

// File: rtl/rps_match_controller.sv
// Stone/paper/scissors match sequencer: collects both players' moves over valid/ready,
// scores each round and declares a match winner by target score or round limit.
module rps_match_controller #(
  parameter int WIN_TARGET     = 3,
  parameter int MAX_ROUNDS     = 9,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p1_ready,
  output logic       p2_ready,
  output logic       round_valid,
  output logic [1:0] round_result,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] round_count,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic       busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] EVAL    = 3'd2;
  localparam logic [2:0] REPORT  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [1:0] MV_STONE    = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_SCISSORS = 2'b10;
  localparam logic [1:0] MV_INVALID  = 2'b11;

  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_NONE = 2'b11;

  localparam logic [3:0] WIN_T   = 4'(WIN_TARGET);
  localparam logic [3:0] MAX_R   = 4'(MAX_ROUNDS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0] state;
  logic       p1_captured;
  logic       p2_captured;
  logic [1:0] p1_move_q;
  logic [1:0] p2_move_q;
  logic [7:0] timeout_cnt;
  logic [1:0] eval_result;
  logic       p1_take;
  logic       p2_take;

  assign p1_ready    = (state == COLLECT) && !p1_captured;
  assign p2_ready    = (state == COLLECT) && !p2_captured;
  assign p1_take     = p1_ready && p1_valid;
  assign p2_take     = p2_ready && p2_valid;
  assign round_valid = (state == REPORT);
  assign match_done  = (state == DONE);
  assign busy        = (state == COLLECT) || (state == EVAL) || (state == REPORT);

  // A missing player forfeits to the present one before any move is inspected.
  always_comb begin
    eval_result = RES_TIE;
    if (!p1_captured && !p2_captured) begin
      eval_result = RES_NONE;
    end else if (!p2_captured) begin
      eval_result = RES_P1;
    end else if (!p1_captured) begin
      eval_result = RES_P2;
    end else if (p1_move_q == MV_INVALID || p2_move_q == MV_INVALID) begin
      eval_result = RES_NONE;
    end else if (p1_move_q == p2_move_q) begin
      eval_result = RES_TIE;
    end else if ((p1_move_q == MV_STONE    && p2_move_q == MV_SCISSORS) ||
                 (p1_move_q == MV_PAPER    && p2_move_q == MV_STONE)    ||
                 (p1_move_q == MV_SCISSORS && p2_move_q == MV_PAPER)) begin
      eval_result = RES_P1;
    end else begin
      eval_result = RES_P2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      p1_captured  <= 1'b0;
      p2_captured  <= 1'b0;
      p1_move_q    <= 2'b00;
      p2_move_q    <= 2'b00;
      timeout_cnt  <= 8'd0;
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      round_count  <= 4'd0;
      round_result <= 2'b00;
      match_winner <= 2'b00;
    end else if (abort) begin
      state        <= IDLE;
      p1_captured  <= 1'b0;
      p2_captured  <= 1'b0;
      timeout_cnt  <= 8'd0;
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      round_count  <= 4'd0;
      round_result <= 2'b00;
      match_winner <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= COLLECT;
            p1_captured  <= 1'b0;
            p2_captured  <= 1'b0;
            timeout_cnt  <= 8'd0;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
            round_count  <= 4'd0;
            round_result <= 2'b00;
            match_winner <= 2'b00;
          end
        end
        COLLECT: begin
          if (p1_take) begin
            p1_captured <= 1'b1;
            p1_move_q   <= p1_move;
          end
          if (p2_take) begin
            p2_captured <= 1'b1;
            p2_move_q   <= p2_move;
          end
          timeout_cnt <= timeout_cnt + 8'd1;
          // A capture landing on the timeout edge still counts toward the round.
          if (((p1_captured || p1_take) && (p2_captured || p2_take)) ||
              (timeout_cnt == TO_LAST)) begin
            state <= EVAL;
          end
        end
        EVAL: begin
          round_result <= eval_result;
          round_count  <= round_count + 4'd1;
          if (eval_result == RES_P1) p1_score <= p1_score + 4'd1;
          if (eval_result == RES_P2) p2_score <= p2_score + 4'd1;
          state <= REPORT;
        end
        REPORT: begin
          if (p1_score == WIN_T) begin
            match_winner <= RES_P1;
            state        <= DONE;
          end else if (p2_score == WIN_T) begin
            match_winner <= RES_P2;
            state        <= DONE;
          end else if (round_count == MAX_R) begin
            if (p1_score > p2_score)      match_winner <= RES_P1;
            else if (p2_score > p1_score) match_winner <= RES_P2;
            else                          match_winner <= RES_TIE;
            state <= DONE;
          end else begin
            p1_captured <= 1'b0;
            p2_captured <= 1'b0;
            timeout_cnt <= 8'd0;
            state       <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
